perfect_scan_sequencer: RTL and testbench

Upstream driver for the perfect-number checker (FSM controller). It walks an inclusive range `[lo, hi]` of 16-bit candidates. For each candidate it drives `num`/`go` into the checker, waits for `over`, samples `display`, and then releases `go` so the checker returns to idle. Perfect candidates are counted and pushed into a small valid/ready result FIFO for downstream consumers.

---
 rtl/perfect_scan_sequencer.sv | 144 ++++++++++++++
 tb/tb_perfect_scan_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perfect_scan_sequencer.sv
// rtl/perfect_scan_sequencer.sv - walks [lo, hi] through the perfect-number checker and queues perfect hits
module perfect_scan_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] num,
    output logic             go,
    input  logic             display,
    input  logic             over,
    output logic             busy,
    output logic             done,
    output logic [7:0]       found_count,
    output logic             overflow,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    input  logic             res_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_accept;
    logic             w_sample;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_num;
    logic             r_go;
    logic             r_busy;
    logic             r_done;
    logic [7:0]       r_found;
    logic             r_overflow;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = (lo > hi) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE:   w_next_state = S_WAIT;
            S_WAIT:    if (over) w_next_state = S_RELEASE;
            // End test on the unincremented candidate keeps hi = all-ones from wrapping.
            S_RELEASE: if (!over) w_next_state = (r_cur == r_hi) ? S_DONE : S_ISSUE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    assign w_sample = (r_state == S_WAIT) && over && display;
    assign w_full   = (r_count == FULL_CNT);
    assign w_pop    = res_valid && res_ready;
    assign w_push   = w_sample && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cur      <= '0;
            r_hi       <= '0;
            r_num      <= '0;
            r_go       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_found    <= '0;
            r_overflow <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_go   <= (w_next_state == S_WAIT);
            r_busy <= (w_next_state == S_ISSUE) || (w_next_state == S_WAIT) ||
                      (w_next_state == S_RELEASE);
            r_done <= (w_next_state == S_DONE);

            if (w_accept) begin
                r_cur      <= lo;
                r_hi       <= hi;
                r_found    <= '0;
                r_overflow <= 1'b0;
            end
            if (r_state == S_ISSUE) r_num <= r_cur;
            if (r_state == S_RELEASE && !over && r_cur != r_hi) r_cur <= r_cur + 1'b1;

            // A dropped hit still counts as found.
            if (w_sample) begin
                if (r_found != 8'hFF) r_found <= r_found + 8'd1;
                if (w_full && !w_pop) r_overflow <= 1'b1;
            end

            if (w_push) begin
                r_mem[r_wr_ptr] <= r_cur;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    assign num         = r_num;
    assign go          = r_go;
    assign busy        = r_busy;
    assign done        = r_done;
    assign found_count = r_found;
    assign overflow    = r_overflow;
    assign res_valid   = (r_count != '0);
    assign res_data    = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_perfect_scan_sequencer.sv
// tb/tb_perfect_scan_sequencer.sv - bench for perfect_scan_sequencer with a behavioural checker
module tb_perfect_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] lo = '0;
    logic [15:0] hi = '0;
    logic [15:0] num;
    logic        go;
    logic        display;
    logic        over;
    logic        busy;
    logic        done;
    logic [7:0]  found_count;
    logic        overflow;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_ready = 1'b0;

    perfect_scan_sequencer #(.WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi),
        .num(num), .go(go), .display(display), .over(over),
        .busy(busy), .done(done), .found_count(found_count), .overflow(overflow),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // chk_mode: 0 = real perfect test, 1 = always perfect, 2 = never perfect
    int chk_mode = 0;
    int lat_min = 0;
    int lat_max = 3;
    int chk_wait = 0;
    int rel_wait = 0;
    // ready_mode: 0 = never, 1 = always, 2 = random, 3 = only on the 5th push cycle
    int ready_mode = 1;
    bit mon_stable_en = 1'b1;
    logic prev_go = 1'b0;
    logic [15:0] held_num = '0;
    int go_nums[$];
    int popped[$];

    typedef struct {
        int lo;
        int hi;
        int mode;
        int rmode;
        int exp_found;
        int exp_ovf;
        int exp_pre;
        int n_pop;
        int pops[5];
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_perfect(input int n);
        int s;
        s = 0;
        if (n < 2) return 1'b0;
        for (int d = 1; d <= n / 2; d++) if (n % d == 0) s += d;
        return s == n;
    endfunction

    initial begin
        over = 1'b0;
        display = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!over) begin
                if (go) begin
                    if (chk_wait <= 0) begin
                        over = 1'b1;
                        display = (chk_mode == 1) ? 1'b1 : (chk_mode == 2) ? 1'b0 : is_perfect(int'(num));
                        rel_wait = $urandom_range(0, 2);
                    end else begin
                        chk_wait--;
                    end
                end else begin
                    chk_wait = $urandom_range(lat_min, lat_max);
                    display = 1'($urandom_range(0, 1));
                end
            end else if (!go) begin
                if (rel_wait <= 0) begin
                    over = 1'b0;
                    display = 1'($urandom_range(0, 1));
                end else begin
                    rel_wait--;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (go && !prev_go) begin
                go_nums.push_back(int'(num));
                held_num = num;
            end else if ((go || prev_go) && mon_stable_en) begin
                chk("num_stable", int'(num), int'(held_num));
            end
            prev_go = go;
            case (ready_mode)
                0:       res_ready = 1'b0;
                1:       res_ready = 1'b1;
                2:       res_ready = 1'($urandom_range(0, 1));
                default: res_ready = go && over && (go_nums.size() >= 5);
            endcase
            if (res_valid && res_ready) popped.push_back(int'(res_data));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, expected finish before 900us");
        $fatal(1, "watchdog");
    end

    task automatic run_scan(input int l, input int h, input int mode, input int rmode,
                            output int found, output int ovf, output int pre);
        int n;
        chk_mode = mode;
        ready_mode = rmode;
        go_nums.delete();
        popped.delete();
        @(posedge clk);
        #1;
        lo = 16'(l);
        hi = 16'(h);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", busy, int'(l <= h));
        chk("done_after_start", done, int'(l > h));
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("scan_completes", int'(n < 20000), 1);
        found = found_count;
        ovf = overflow;
        pre = popped.size();
        chk("busy_at_done", busy, 0);
        ready_mode = 1;
        n = 0;
        while (res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("fifo_drained", res_valid, 0);
    endtask

    task automatic model_check(input int l, input int h, input int mode, input int found, input int ovf);
        int exp[$];
        int j;
        bit ok;
        int n_go;
        if (l <= h) for (int c = l; c <= h; c++) if (mode == 1 || (mode == 0 && is_perfect(c))) exp.push_back(c);
        n_go = (l <= h) ? h - l + 1 : 0;
        chk("go_pulses", go_nums.size(), n_go);
        ok = 1'b1;
        foreach (go_nums[k]) if (go_nums[k] != l + k) ok = 1'b0;
        chk("go_num_sequence", int'(ok), 1);
        chk("found_count", found, (exp.size() > 255) ? 255 : exp.size());
        chk("overflow_vs_drops", ovf, int'(popped.size() < exp.size()));
        j = 0;
        ok = (popped.size() <= exp.size());
        foreach (popped[k]) begin
            while (j < exp.size() && exp[j] != popped[k]) j++;
            if (j >= exp.size()) ok = 1'b0;
            else j++;
        end
        chk("pop_order", int'(ok), 1);
    endtask

    initial begin
        int found, ovf, pre, l, h, mode, rm, n;

        tbl[0] = '{1, 30, 0, 1, 2, 0, -1, 2, '{6, 28, 0, 0, 0}};
        tbl[1] = '{40, 10, 0, 1, 0, 0, 0, 0, '{0, 0, 0, 0, 0}};
        tbl[2] = '{10, 15, 1, 0, 6, 1, 0, 4, '{10, 11, 12, 13, 0}};
        tbl[3] = '{20, 24, 1, 3, 5, 0, 1, 5, '{20, 21, 22, 23, 24}};
        tbl[4] = '{65534, 65535, 2, 1, 0, 0, 0, 0, '{0, 0, 0, 0, 0}};
        tbl[5] = '{494, 500, 0, 2, 1, 0, -1, 1, '{496, 0, 0, 0, 0}};
        tbl[6] = '{0, 299, 1, 1, 255, 0, -1, -1, '{0, 0, 0, 0, 0}};

        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_go", go, 0);
        chk("rst_num", int'(num), 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_found", int'(found_count), 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", int'(res_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_scan(tbl[i].lo, tbl[i].hi, tbl[i].mode, tbl[i].rmode, found, ovf, pre);
            model_check(tbl[i].lo, tbl[i].hi, tbl[i].mode, found, ovf);
            chk("tbl_found", found, tbl[i].exp_found);
            chk("tbl_overflow", ovf, tbl[i].exp_ovf);
            if (tbl[i].exp_pre >= 0) chk("tbl_pops_before_done", pre, tbl[i].exp_pre);
            if (tbl[i].n_pop >= 0) begin
                chk("tbl_pop_count", popped.size(), tbl[i].n_pop);
                for (int k = 0; k < tbl[i].n_pop && k < popped.size(); k++)
                    chk("tbl_pop_value", popped[k], tbl[i].pops[k]);
            end
        end

        repeat (12) begin
            l = $urandom_range(0, 560);
            if ($urandom_range(0, 7) == 0) h = (l > 5) ? l - int'($urandom_range(1, 5)) : l;
            else h = l + int'($urandom_range(0, 30));
            mode = $urandom_range(0, 2);
            rm = $urandom_range(1, 2);
            lat_max = $urandom_range(0, 3);
            run_scan(l, h, mode, rm, found, ovf, pre);
            model_check(l, h, mode, found, ovf);
        end

        // Reset while candidate 28 is waiting on the checker.
        lat_min = 5;
        lat_max = 5;
        chk_mode = 0;
        ready_mode = 0;
        go_nums.delete();
        popped.delete();
        @(posedge clk);
        #1;
        lo = 16'd1;
        hi = 16'd30;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!(go && go_nums.size() > 0 && go_nums[go_nums.size()-1] == 28) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_wait_28", int'(n < 2000), 1);
        chk("pre_rst_valid", res_valid, 1);
        chk("pre_rst_head", int'(res_data), 6);
        mon_stable_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_go", go, 0);
        chk("midrst_num", int'(num), 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_found", int'(found_count), 0);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_res_data", int'(res_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mon_stable_en = 1'b1;
        lat_min = 0;
        lat_max = 3;
        run_scan(6, 6, 0, 1, found, ovf, pre);
        model_check(6, 6, 0, found, ovf);
        chk("post_rst_found", found, 1);
        chk("post_rst_pop_count", popped.size(), 1);
        if (popped.size() > 0) chk("post_rst_pop_value", popped[0], 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
